// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register (in: clk, rst, stall, flush, ex_*, hilo_i, cnt_i; out: mem_*, hilo_o, cnt_o fed back to EX)
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o
);
  logic [ADDR_W-1:0]   mem_wd_q, mem_wd_d;
  logic                mem_wreg_q, mem_wreg_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   mem_hi_q, mem_hi_d;
  logic [DATA_W-1:0]   mem_lo_q, mem_lo_d;
  logic                mem_whilo_q, mem_whilo_d;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clr, hold, mem_clr, acc_clr;
  always_comb begin
    clr         = rst | flush;
    hold        = stall[3] & stall[4];
    mem_clr     = clr | (stall[3] & ~stall[4]);
    acc_clr     = clr | ~stall[3];
    mem_wd_d    = mem_clr ? '0 : hold ? mem_wd_q    : ex_wd;
    mem_wreg_d  = mem_clr ? '0 : hold ? mem_wreg_q  : ex_wreg;
    mem_wdata_d = mem_clr ? '0 : hold ? mem_wdata_q : ex_wdata;
    mem_hi_d    = mem_clr ? '0 : hold ? mem_hi_q    : ex_hi;
    mem_lo_d    = mem_clr ? '0 : hold ? mem_lo_q    : ex_lo;
    mem_whilo_d = mem_clr ? '0 : hold ? mem_whilo_q : ex_whilo;
    hilo_d      = acc_clr ? '0 : hold ? hilo_q      : hilo_i;
    cnt_d       = acc_clr ? '0 : hold ? cnt_q       : cnt_i;
  end
  always_ff @(posedge clk) begin
    mem_wd_q    <= mem_wd_d;
    mem_wreg_q  <= mem_wreg_d;
    mem_wdata_q <= mem_wdata_d;
    mem_hi_q    <= mem_hi_d;
    mem_lo_q    <= mem_lo_d;
    mem_whilo_q <= mem_whilo_d;
    hilo_q      <= hilo_d;
    cnt_q       <= cnt_d;
  end
  assign mem_wd    = mem_wd_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_hi    = mem_hi_q;
  assign mem_lo    = mem_lo_q;
  assign mem_whilo = mem_whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: scoreboard bench for ex_mem_reg with directed vectors
module tb_ex_mem_reg;
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;
  logic        clk = 0;
  logic        rst, flush, ex_wreg, ex_whilo, mem_wreg, mem_whilo;
  logic [5:0]  stall;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo, mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_i, hilo_o;
  logic [1:0]  cnt_i, cnt_o;
  out_t        q[$];
  int          n = 0, fails = 0;
  always #5 clk = ~clk;
  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );
  always @(posedge clk) assert (!(!stall[3] && stall[4])) else $error("illegal stall combination %b", stall);
  function automatic out_t mk(logic [4:0] wd, logic wreg, logic [31:0] wdata, logic [31:0] hi,
                              logic [31:0] lo, logic whilo, logic [63:0] hilo, logic [1:0] cnt);
    mk = '{wd, wreg, wdata, hi, lo, whilo, hilo, cnt};
  endfunction
  task automatic drv(string name, logic r, logic f, logic [5:0] s, logic [4:0] wd, logic wreg,
                     logic [31:0] wdata, logic [31:0] hi, logic [31:0] lo, logic whilo,
                     logic [63:0] hl, logic [1:0] c, out_t e);
    rst = r; flush = f; stall = s; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_hi = hi; ex_lo = lo; ex_whilo = whilo; hilo_i = hl; cnt_i = c;
    q.push_back(e);
    names.push_back(name);
    @(negedge clk);
  endtask
  string names[$];
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      out_t e, a;
      string nm;
      e = q.pop_front();
      nm = names.pop_front();
      a = '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};
      n++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h, expected wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h",
                 nm, a.wd, a.wreg, a.wdata, a.hi, a.lo, a.whilo, a.hilo, a.cnt,
                 e.wd, e.wreg, e.wdata, e.hi, e.lo, e.whilo, e.hilo, e.cnt);
      end
    end
  end
  initial begin
    drv("reset0", 1, 0, 6'b000000, 5'd7, 1, 32'hFFFF_FFFF, 32'h1, 32'h2, 1, 64'h5, 2'd3, mk(0, 0, 0, 0, 0, 0, 0, 0));
    drv("reset1", 1, 0, 6'b001000, 5'd7, 1, 32'hFFFF_FFFF, 32'h1, 32'h2, 1, 64'h5, 2'd3, mk(0, 0, 0, 0, 0, 0, 0, 0));
    drv("advance", 0, 0, 6'b000000, 5'd3, 1, 32'h1234_5678, 0, 0, 0, 64'h0, 2'd0, mk(3, 1, 32'h1234_5678, 0, 0, 0, 0, 0));
    drv("hilo_pass", 0, 0, 6'b000000, 5'd3, 1, 32'h1234_5678, 32'hAAAA_0000, 32'h0000_5555, 1, 64'h0, 2'd0,
        mk(3, 1, 32'h1234_5678, 32'hAAAA_0000, 32'h0000_5555, 1, 0, 0));
    drv("whilo_off", 0, 0, 6'b000000, 5'd3, 1, 32'h1234_5678, 32'hAAAA_0000, 32'h0000_5555, 0, 64'h0, 2'd0,
        mk(3, 1, 32'h1234_5678, 32'hAAAA_0000, 32'h0000_5555, 0, 0, 0));
    drv("bubble_acc", 0, 0, 6'b001000, 5'd3, 1, 32'h1234_5678, 32'hAAAA_0000, 32'h0000_5555, 1, 64'h0000_0001_FFFF_FFFF, 2'd1,
        mk(0, 0, 0, 0, 0, 0, 64'h0000_0001_FFFF_FFFF, 1));
    drv("bubble_release", 0, 0, 6'b000000, 5'd9, 1, 32'hCAFE_F00D, 32'hAAAA_0000, 32'h0000_5555, 0, 64'h0000_0001_FFFF_FFFF, 2'd2,
        mk(9, 1, 32'hCAFE_F00D, 32'hAAAA_0000, 32'h0000_5555, 0, 0, 0));
    drv("load_beef", 0, 0, 6'b000000, 5'h1F, 1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 1, 64'h0, 2'd0,
        mk(5'h1F, 1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      drv("hold_mem", 0, 0, 6'b011000, 5'(i), 0, 32'(i), 32'(i + 8), 32'(i + 9), 0, 64'(i + 1), 2'd3,
          mk(5'h1F, 1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 1, 0, 0));
    drv("bubble_load", 0, 0, 6'b001000, 5'd6, 1, 32'h6666_6666, 32'h7, 32'h8, 1, 64'h1111_2222_3333_4444, 2'd2,
        mk(0, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 2));
    drv("hold_acc", 0, 0, 6'b011000, 5'd6, 1, 32'h6666_6666, 32'h7, 32'h8, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
        mk(0, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 2));
    drv("flush_acc", 0, 1, 6'b011000, 5'd6, 1, 32'h6666_6666, 32'h7, 32'h8, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
        mk(0, 0, 0, 0, 0, 0, 0, 0));
    drv("reload", 0, 0, 6'b000000, 5'd2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 64'h9, 2'd1,
        mk(2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 0, 0));
    drv("flush_mem", 0, 1, 6'b011000, 5'd2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 64'h9, 2'd1,
        mk(0, 0, 0, 0, 0, 0, 0, 0));
    drv("after_flush", 0, 0, 6'b000000, 5'd2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 64'h9, 2'd1,
        mk(2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 0, 0));
    drv("bubble_mid", 0, 0, 6'b001000, 5'd2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 64'hABCD, 2'd1,
        mk(0, 0, 0, 0, 0, 0, 64'hABCD, 1));
    drv("reset_mid", 1, 0, 6'b001000, 5'd2, 1, 32'h55AA_55AA, 32'h1, 32'h2, 1, 64'hABCD, 2'd1,
        mk(0, 0, 0, 0, 0, 0, 0, 0));
    drv("after_reset", 0, 0, 6'b000000, 5'd12, 1, 32'h0BAD_F00D, 32'h3, 32'h4, 0, 64'hABCD, 2'd1,
        mk(12, 1, 32'h0BAD_F00D, 32'h3, 32'h4, 0, 0, 0));
    drv("ignored_bits", 0, 0, 6'b100111, 5'd4, 0, 32'h1357_9BDF, 32'h5, 32'h6, 1, 64'h77, 2'd2,
        mk(4, 0, 32'h1357_9BDF, 32'h5, 32'h6, 1, 0, 0));
    drv("rst_over_flush", 1, 1, 6'b011000, 5'd4, 0, 32'h1357_9BDF, 32'h5, 32'h6, 1, 64'h77, 2'd2,
        mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 0; flush = 0; stall = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures the EX results: destination register index, write enable, write data, HI/LO write-back triple.
- Handles pipeline stall, bubble insertion and flush.
- Holds the multi-cycle accumulation state (`hilo_temp`, `cnt`) that EX hands back to itself for two-cycle ops (madd/maddu/msub/msubu).

Parameters:
- `DATA_W`, 32, general register / HI / LO width
- `ADDR_W`, 5, register-file address width
- `CNT_W`, 2, multi-cycle op cycle counter width

Ports:
- `clk` input 1 rising-edge clock
- `rst` input 1 reset, synchronous, active-high
- `stall` input 6 pipeline stall vector, one bit per stage; bit 3 = EX stalled, bit 4 = MEM stalled
- `flush` input 1 pipeline flush (exception), synchronous clear
- `ex_wd` input `ADDR_W` EX destination register index
- `ex_wreg` input 1 EX register write enable
- `ex_wdata` input `DATA_W` EX result
- `ex_hi` input `DATA_W` EX HI value
- `ex_lo` input `DATA_W` EX LO value
- `ex_whilo` input 1 EX HI/LO write enable
- `hilo_i` input 2*`DATA_W` EX partial 64-bit accumulation result
- `cnt_i` input `CNT_W` EX multi-cycle step count
- `mem_wd` output `ADDR_W` registered destination index
- `mem_wreg` output 1 registered write enable
- `mem_wdata` output `DATA_W` registered result
- `mem_hi` output `DATA_W` registered HI
- `mem_lo` output `DATA_W` registered LO
- `mem_whilo` output 1 registered HI/LO write enable
- `hilo_o` output 2*`DATA_W` accumulation state fed back to EX
- `cnt_o` output `CNT_W` step count fed back to EX

Behaviour:
- All outputs are registered and update only on the rising edge of `clk`. There are no combinational paths from inputs to outputs. Latency is 1 cycle.
- Reset: when `rst`=1 at a clock edge, every output is cleared to 0. Reset has the highest priority.
- Flush: when `flush`=1 (and `rst`=0), every output is cleared to 0, including `hilo_o` and `cnt_o`. Flush aborts any in-progress multi-cycle op and takes priority over stall.
- Stall decode has three modes, selected by bits 3 and 4 of `stall`:
  - Bubble (`stall[3]`=1, `stall[4]`=0):
    - `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_hi`, `mem_lo`, `mem_whilo` are cleared to 0, so MEM sees a NOP.
    - `hilo_o` <= `hilo_i` and `cnt_o` <= `cnt_i`, so EX keeps its partial accumulation across the stall it raised itself.
  - Hold (`stall[3]`=1, `stall[4]`=1): every output keeps its value, including `hilo_o` and `cnt_o`.
  - Advance (`stall[3]`=0):
    - All `mem_*` outputs latch the corresponding `ex_*` inputs.
    - `hilo_o` and `cnt_o` clear to 0, because the multi-cycle op has completed and left EX.
  - `stall[3]`=0 with `stall[4]`=1 is an illegal combination. It is treated as Advance. The stall controller never produces it, and the bench flags it with an assertion.
- Only `stall` bits 3 and 4 are used. The other bits are ignored.
- No arithmetic is performed. Widths pass through unchanged.
- The HI/LO triple is written atomically: `mem_hi`, `mem_lo` and `mem_whilo` always update together. EX forwarding reads `mem_hi`, `mem_lo` and `mem_whilo` combinationally from this register's outputs.
- Simultaneous events, in priority order: `rst` > `flush` > Hold > Bubble > Advance.
- Reset or flush asserted mid multi-cycle op: `cnt_o` returns to 0 on that edge. On the first cycle after release, EX restarts the op from step 0.

Test Plan:
- Reset then Advance:
  - Stimulus: drive `rst`=1 for 2 cycles, then drive `ex_wd`=5'd3, `ex_wreg`=1, `ex_wdata`=32'h1234_5678, `stall`=0.
  - Response: all outputs are 0 during reset. One edge after release, `mem_wd`=3, `mem_wreg`=1, `mem_wdata`=32'h1234_5678.
- HI/LO pass:
  - Stimulus: `ex_hi`=32'hAAAA_0000, `ex_lo`=32'h0000_5555, `ex_whilo`=1.
  - Response: next cycle `mem_hi`, `mem_lo` and `mem_whilo` carry exactly these values. The following cycle, with `ex_whilo`=0, `mem_whilo`=0.
- Bubble with accumulation:
  - Stimulus: `stall`=6'b001000, `hilo_i`=64'h0000_0001_FFFF_FFFF, `cnt_i`=1, `ex_wreg`=1.
  - Response: `mem_wreg`=0, `mem_wdata`=0, `hilo_o`=64'h0000_0001_FFFF_FFFF, `cnt_o`=1.
  - Stimulus: next cycle `stall`=0.
  - Response: `cnt_o`=0, `hilo_o`=0, `mem_*` = EX values.
- Hold:
  - Stimulus: load `mem_wdata`=32'hDEAD_BEEF, then drive `stall`=6'b011000 for 3 cycles while changing all `ex_*` inputs.
  - Response: all outputs stay unchanged, including `hilo_o` and `cnt_o`.
- Flush priority:
  - Stimulus: `flush`=1 together with `stall`=6'b011000 and nonzero state in every output.
  - Response: all outputs are 0 on the next edge.
- Reset mid op:
  - Stimulus: `cnt_o`=1 from a Bubble cycle, then `rst`=1 for one cycle.
  - Response: `cnt_o`=0 and `hilo_o`=0. After release with `stall`=0, normal Advance resumes.
